// File: rtl/cntr_pkg.sv
// Shared encodings for the cntr_param counter slice.
package cntr_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'o0;
  localparam logic [ST_W-1:0] ST_LOAD = 3'o1;
  localparam logic [ST_W-1:0] ST_INC  = 3'o2;
  localparam logic [ST_W-1:0] ST_INC2 = 3'o3;
  localparam logic [ST_W-1:0] ST_DEC  = 3'o4;
  localparam logic [ST_W-1:0] ST_DEC2 = 3'o5;

endpackage

// File: rtl/cntr_param_if.sv
// Control/data bundle between a counter client and cntr_param.
interface cntr_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             load;
  logic             inc;
  logic             sat_en;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic [2:0]       o_state;
  logic             at_max;
  logic             at_min;
  logic             wrap;

  modport master (
    output en, load, inc, sat_en, d_in,
    input  d_out, o_state, at_max, at_min, wrap
  );

  modport slave (
    input  en, load, inc, sat_en, d_in,
    output d_out, o_state, at_max, at_min, wrap
  );
endinterface

// File: rtl/cntr_step_logic.sv
// Combinational count-event arithmetic for the state being entered.
module cntr_step_logic
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned HALF_RATE = 0
) (
  input  logic [ST_W-1:0]  state_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             sat_en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH:0] StepExt = (WIDTH + 1)'(STEP);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           is_up;
  logic           is_dn;
  logic           counts;

  always_comb begin
    sum     = {1'b0, count_i} + StepExt;
    diff    = {1'b0, count_i} - StepExt;
    is_up   = (state_i == ST_INC) || (state_i == ST_INC2);
    is_dn   = (state_i == ST_DEC) || (state_i == ST_DEC2);
    counts  = (HALF_RATE == 0) || (state_i == ST_INC2) || (state_i == ST_DEC2);
    count_o = count_i;
    wrap_o  = 1'b0;
    // Bit WIDTH of sum/diff is the carry/borrow, i.e. a limit crossing.
    if (counts && is_up) begin
      if (sum[WIDTH] && sat_en_i) begin
        count_o = '1;
      end else begin
        count_o = sum[WIDTH-1:0];
        wrap_o  = sum[WIDTH];
      end
    end else if (counts && is_dn) begin
      if (diff[WIDTH] && sat_en_i) begin
        count_o = '0;
      end else begin
        count_o = diff[WIDTH-1:0];
        wrap_o  = diff[WIDTH];
      end
    end
  end

endmodule

// File: rtl/cntr_param.sv
// Parametrised up/down counter with load, step, half-rate, saturate/wrap and flags.
module cntr_param
  import cntr_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned HALF_RATE = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  cntr_param_if.slave  bus
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;

  always_comb begin
    state_d = ST_IDLE;
    if (state_q > ST_DEC2) begin
      state_d = ST_IDLE;
    end else if (bus.load) begin
      state_d = ST_LOAD;
    end else if (!bus.en) begin
      state_d = ST_IDLE;
    end else if (bus.inc) begin
      state_d = (state_q == ST_INC) ? ST_INC2 : ST_INC;
    end else begin
      state_d = (state_q == ST_DEC) ? ST_DEC2 : ST_DEC;
    end
  end

  // Arithmetic is evaluated for the state being entered, not the current one.
  cntr_step_logic #(
    .WIDTH     (WIDTH),
    .STEP      (STEP),
    .HALF_RATE (HALF_RATE)
  ) u_step (
    .state_i  (state_d),
    .count_i  (count_q),
    .sat_en_i (bus.sat_en),
    .count_o  (step_count),
    .wrap_o   (step_wrap)
  );

  always_comb begin
    count_d = step_count;
    wrap_d  = step_wrap;
    if (state_d == ST_LOAD) begin
      count_d = bus.d_in;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.d_out   = count_q;
  assign bus.o_state = state_q;
  assign bus.wrap    = wrap_q;
  assign bus.at_max  = &count_q;
  assign bus.at_min  = ~|count_q;

endmodule

// File: tb/tb_cntr_param.sv
// Directed + random bench for cntr_param: DUT A (STEP=1) and DUT B (STEP=3, half rate).
module tb_cntr_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cntr_param_if #(.WIDTH(8)) bus_a ();
  cntr_param_if #(.WIDTH(8)) bus_b ();

  cntr_param #(.WIDTH(8), .STEP(1), .HALF_RATE(0)) u_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  cntr_param #(.WIDTH(8), .STEP(3), .HALF_RATE(1)) u_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0 idle, 1 loaded, 2 counting up, 3 counting down; ph = second beat.
  int m_mode[2] = '{0, 0};
  int m_ph[2]   = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  int m_wrap[2] = '{0, 0};
  int m_step[2] = '{1, 3};
  int m_half[2] = '{0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_state(input int k);
    case (m_mode[k])
      0:       return 0;
      1:       return 1;
      2:       return 2 + m_ph[k];
      default: return 4 + m_ph[k];
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_ph[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0;
    end
  endtask

  task automatic model_clock(input bit l, input bit e, input bit i, input bit s,
                             input int din);
    int v;
    int dir;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      if (l) begin
        m_mode[k] = 1; m_ph[k] = 0; m_cnt[k] = din;
      end else if (!e) begin
        m_mode[k] = 0; m_ph[k] = 0;
      end else begin
        dir = i ? 2 : 3;
        m_ph[k] = (m_mode[k] == dir) ? 1 - m_ph[k] : 0;
        m_mode[k] = dir;
        if (m_half[k] == 0 || m_ph[k] == 1) begin
          v = i ? m_cnt[k] + m_step[k] : m_cnt[k] - m_step[k];
          if (v > 255 || v < 0) begin
            if (s) begin
              v = (v > 255) ? 255 : 0;
            end else begin
              v = (v > 255) ? v - 256 : v + 256;
              m_wrap[k] = 1;
            end
          end
          m_cnt[k] = v;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_a_st"}, 32'(bus_a.o_state), exp_state(0));
    check({tag, "_a_d"},  32'(bus_a.d_out),   m_cnt[0]);
    check({tag, "_a_wr"}, 32'(bus_a.wrap),    m_wrap[0]);
    check({tag, "_a_mx"}, 32'(bus_a.at_max),  (m_cnt[0] == 255) ? 1 : 0);
    check({tag, "_a_mn"}, 32'(bus_a.at_min),  (m_cnt[0] == 0) ? 1 : 0);
    check({tag, "_b_st"}, 32'(bus_b.o_state), exp_state(1));
    check({tag, "_b_d"},  32'(bus_b.d_out),   m_cnt[1]);
    check({tag, "_b_wr"}, 32'(bus_b.wrap),    m_wrap[1]);
    check({tag, "_b_mx"}, 32'(bus_b.at_max),  (m_cnt[1] == 255) ? 1 : 0);
    check({tag, "_b_mn"}, 32'(bus_b.at_min),  (m_cnt[1] == 0) ? 1 : 0);
  endtask

  task automatic step(input string tag, input bit l, input bit e, input bit i, input bit s,
                      input int din);
    bus_a.load = l; bus_a.en = e; bus_a.inc = i; bus_a.sat_en = s; bus_a.d_in = 8'(din);
    bus_b.load = l; bus_b.en = e; bus_b.inc = i; bus_b.sat_en = s; bus_b.d_in = 8'(din);
    @(posedge clk);
    model_clock(l, e, i, s, din);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [7:0] ed2[4];
    logic [7:0] ed5[4];
    logic [2:0] es[4];
    bit         l, e, i, s;
    int         din;

    step_inputs_idle: begin
      bus_a.load = 0; bus_a.en = 0; bus_a.inc = 0; bus_a.sat_en = 0; bus_a.d_in = '0;
      bus_b.load = 0; bus_b.en = 0; bus_b.inc = 0; bus_b.sat_en = 0; bus_b.d_in = '0;
    end
    #1;
    check_model("rst");
    #11 reset_n = 1'b1;

    // Async reset mid-count at 8'h37.
    step("pre", 1, 0, 0, 0, 'h36);
    step("cnt", 0, 1, 1, 0, 0);
    check("t1_pre_d", 32'(bus_a.d_out), 32'h37);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check("t1_d",  32'(bus_a.d_out),   32'h0);
    check("t1_st", 32'(bus_a.o_state), 32'h0);
    check("t1_mn", 32'(bus_a.at_min),  32'h1);
    check_model("t1");
    #2 reset_n = 1'b1;
    step("t1_rel", 0, 1, 1, 0, 0);
    check("t1_rel_st", 32'(bus_a.o_state), 32'h2);
    check("t1_rel_d",  32'(bus_a.d_out),   32'h1);

    // Load then count up x4.
    step("t2_ld", 1, 0, 0, 0, 'h0F);
    check("t2_ld_st", 32'(bus_a.o_state), 32'h1);
    check("t2_ld_d",  32'(bus_a.d_out),   32'h0F);
    ed2 = '{8'h10, 8'h11, 8'h12, 8'h13};
    es  = '{3'd2, 3'd3, 3'd2, 3'd3};
    for (int n = 0; n < 4; n++) begin
      step("t2", 0, 1, 1, 0, 0);
      check("t2_st", 32'(bus_a.o_state), 32'(es[n]));
      check("t2_d",  32'(bus_a.d_out),   32'(ed2[n]));
    end

    // Wrap through the top.
    step("t3_ld", 1, 0, 0, 0, 'hFE);
    step("t3", 0, 1, 1, 0, 0);
    check("t3_d0", 32'(bus_a.d_out), 32'hFF);
    check("t3_mx", 32'(bus_a.at_max), 32'h1);
    check("t3_w0", 32'(bus_a.wrap), 32'h0);
    step("t3", 0, 1, 1, 0, 0);
    check("t3_d1", 32'(bus_a.d_out), 32'h00);
    check("t3_w1", 32'(bus_a.wrap), 32'h1);
    step("t3", 0, 1, 1, 0, 0);
    check("t3_d2", 32'(bus_a.d_out), 32'h01);
    check("t3_w2", 32'(bus_a.wrap), 32'h0);

    // Saturate at zero.
    step("t4_ld", 1, 0, 0, 1, 'h01);
    for (int n = 0; n < 3; n++) begin
      step("t4", 0, 1, 0, 1, 0);
      check("t4_d",  32'(bus_a.d_out),  32'h00);
      check("t4_mn", 32'(bus_a.at_min), 32'h1);
      check("t4_w",  32'(bus_a.wrap),   32'h0);
    end

    // Half-rate, STEP=3 on DUT B.
    step("t5_ld", 1, 0, 0, 0, 'h10);
    ed5 = '{8'h10, 8'h13, 8'h13, 8'h16};
    for (int n = 0; n < 4; n++) begin
      step("t5", 0, 1, 1, 0, 0);
      check("t5_st", 32'(bus_b.o_state), 32'(es[n]));
      check("t5_d",  32'(bus_b.d_out),   32'(ed5[n]));
    end

    // Load beats count; then idle holds.
    step("t6", 1, 1, 1, 0, 'hA5);
    check("t6_st", 32'(bus_a.o_state), 32'h1);
    check("t6_d",  32'(bus_a.d_out),   32'hA5);
    check("t6_w",  32'(bus_a.wrap),    32'h0);
    step("t6_idle", 0, 0, 1, 0, 0);
    check("t6_idle_st", 32'(bus_a.o_state), 32'h0);
    check("t6_idle_d",  32'(bus_a.d_out),   32'hA5);

    // Random runs, biased toward the limits.
    i = 1'b1;
    for (int n = 0; n < 400; n++) begin
      l = ($urandom_range(0, 11) == 0);
      e = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) i = ~i;
      s = ($urandom_range(0, 3) == 0) ? ~s : s;
      case ($urandom_range(0, 4))
        0:       din = 0;
        1:       din = 1;
        2:       din = 'hFE;
        3:       din = 'hFF;
        default: din = int'($urandom_range(0, 255));
      endcase
      step("rnd", l, e, i, s, din);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
